// File: rtl/yalu_arbiter_if.sv
// Request/response bundle between the two issue sources, the result consumer and yalu_arbiter.
// master: requesters plus consumer; slave: the arbiter.
interface yalu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req1_valid;
  logic [2:0]       req0_op;
  logic [2:0]       req1_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             gnt0;
  logic             gnt1;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_z;
  logic             resp_ex;
  logic             resp_id;
  logic             resp_err;

  modport master (
    output req0_valid, req1_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b,
    output resp_ready,
    input  gnt0, gnt1, resp_valid, resp_z, resp_ex, resp_id, resp_err
  );

  modport slave (
    input  req0_valid, req1_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b,
    input  resp_ready,
    output gnt0, gnt1, resp_valid, resp_z, resp_ex, resp_id, resp_err
  );
endinterface

// File: rtl/yalu_arbiter.sv
// Shares one yAlu-equivalent datapath between two requesters: IDLE -> EXEC -> RESP sequencing.
// Define YALU_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise requester 0 has fixed priority.
module yalu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  yalu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic             grant_win_s;
  logic             pick1_s;
  logic             gnt0_s;
  logic             gnt1_s;
  logic             gnt_any_s;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             id_r;
  logic [WIDTH+1:0] alu_s;
  logic             resp_valid_r;
  logic [WIDTH-1:0] resp_z_r;
  logic             resp_ex_r;
  logic             resp_id_r;
  logic             resp_err_r;

  // yAlu behaviour: returns {err, ex, z}; ex is the zero flag, forced low with z on an illegal opcode.
  function automatic logic [WIDTH+1:0] alu_eval(input logic [2:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] z;
    logic             err;
    z   = '0;
    err = 1'b0;
    case (op)
      3'd0:    z = a & b;
      3'd1:    z = a | b;
      3'd2:    z = a + b;
      3'd6:    z = a - b;
      3'd7:    z = ($signed(a) < $signed(b)) ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
      default: begin
        z   = '0;
        err = 1'b1;
      end
    endcase
    return {err, (~err) & (z == '0), z};
  endfunction

`ifdef YALU_ARB_ROUND_ROBIN_EN
  logic ptr_r;

  // Round-robin pointer: after a grant it points at the requester that was not served.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_r <= 1'b0;
    end else if (gnt_any_s) begin
      ptr_r <= gnt0_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign pick1_s = ptr_r;
`else
  assign pick1_s = 1'b0;
`endif

  // Grant window and one-hot arbitration.
  always_comb begin
    grant_win_s = 1'b0;
    gnt0_s      = 1'b0;
    gnt1_s      = 1'b0;
    if (!rst_n) begin
      grant_win_s = 1'b0;
    end else if (state_r == IDLE) begin
      grant_win_s = 1'b1;
    end else if ((state_r == RESP) && bus.resp_ready) begin
      grant_win_s = 1'b1;
    end else begin
      grant_win_s = 1'b0;
    end
    if (grant_win_s) begin
      if (bus.req0_valid && bus.req1_valid) begin
        gnt0_s = ~pick1_s;
        gnt1_s = pick1_s;
      end else begin
        gnt0_s = bus.req0_valid;
        gnt1_s = bus.req1_valid;
      end
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  assign gnt_any_s = gnt0_s | gnt1_s;

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (gnt_any_s) begin
          state_s = EXEC;
        end else begin
          state_s = IDLE;
        end
      end
      EXEC: state_s = RESP;
      RESP: begin
        if (bus.resp_ready) begin
          state_s = gnt_any_s ? EXEC : IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand registers; the ALU sees only these, never the live request lines.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_r <= 3'd0;
      a_r  <= '0;
      b_r  <= '0;
      id_r <= 1'b0;
    end else if (gnt_any_s) begin
      op_r <= gnt1_s ? bus.req1_op : bus.req0_op;
      a_r  <= gnt1_s ? bus.req1_a  : bus.req0_a;
      b_r  <= gnt1_s ? bus.req1_b  : bus.req0_b;
      id_r <= gnt1_s;
    end else begin
      op_r <= op_r;
      a_r  <= a_r;
      b_r  <= b_r;
      id_r <= id_r;
    end
  end

  assign alu_s = alu_eval(op_r, a_r, b_r);

  // Result registers, captured at the end of EXEC and held through RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_z_r   <= '0;
      resp_ex_r  <= 1'b0;
      resp_id_r  <= 1'b0;
      resp_err_r <= 1'b0;
    end else if (state_r == EXEC) begin
      resp_z_r   <= alu_s[WIDTH-1:0];
      resp_ex_r  <= alu_s[WIDTH];
      resp_id_r  <= id_r;
      resp_err_r <= alu_s[WIDTH+1];
    end else begin
      resp_z_r   <= resp_z_r;
      resp_ex_r  <= resp_ex_r;
      resp_id_r  <= resp_id_r;
      resp_err_r <= resp_err_r;
    end
  end

  // Response valid mirrors the registered RESP state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_valid_r <= 1'b0;
    end else begin
      resp_valid_r <= (state_s == RESP);
    end
  end

  assign bus.gnt0       = gnt0_s;
  assign bus.gnt1       = gnt1_s;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_z     = resp_z_r;
  assign bus.resp_ex    = resp_ex_r;
  assign bus.resp_id    = resp_id_r;
  assign bus.resp_err   = resp_err_r;

endmodule

// File: tb/tb_yalu_arbiter.sv
// Self-checking bench for yalu_arbiter: vector table, scoreboard monitor and corner-case sequences.
// Build with or without YALU_ARB_ROUND_ROBIN_EN, matching the RTL build.
module tb_yalu_arbiter;

  typedef struct {
    logic        id;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;
    logic        ex;
    logic        err;
  } vec_t;

  logic clk;
  logic rst_n;
  int   vec_cnt;
  int   miss_cnt;
  logic [34:0] sbq[$];
  vec_t tbl[12];

  yalu_arbiter_if bus ();

  yalu_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: {id, err, ex, z}, ex is the zero flag of a legal result.
  function automatic logic [34:0] model(input logic id, input logic [2:0] op,
                                        input logic [31:0] a, input logic [31:0] b);
    logic [31:0] z;
    logic        err;
    err = 1'b0;
    case (op)
      3'd0: z = a & b;
      3'd1: z = a | b;
      3'd2: z = a + b;
      3'd6: z = a - b;
      3'd7: z = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: begin
        z   = 32'd0;
        err = 1'b1;
      end
    endcase
    return {id, err, (!err && z == 32'd0), z};
  endfunction

  // Scoreboard: push on grant, pop on response handshake.
  always @(negedge clk) begin
    logic [34:0] e;
    if (rst_n !== 1'b1) begin
      sbq.delete();
    end else begin
      if (bus.gnt0 === 1'b1 || bus.gnt1 === 1'b1) begin
        chk("gnt_onehot", {63'd0, bus.gnt0 & bus.gnt1}, 64'd0);
        if (bus.gnt0 === 1'b1) begin
          chk("gnt0_needs_valid", {63'd0, bus.req0_valid}, 64'd1);
          sbq.push_back(model(1'b0, bus.req0_op, bus.req0_a, bus.req0_b));
        end else begin
          chk("gnt1_needs_valid", {63'd0, bus.req1_valid}, 64'd1);
          sbq.push_back(model(1'b1, bus.req1_op, bus.req1_a, bus.req1_b));
        end
      end
      if (bus.resp_valid === 1'b1 && bus.resp_ready === 1'b1) begin
        if (sbq.size() == 0) begin
          chk("sb_unexpected_resp", 64'd1, 64'd0);
        end else begin
          e = sbq.pop_front();
          chk("sb_resp", {29'd0, bus.resp_id, bus.resp_err, bus.resp_ex, bus.resp_z}, {29'd0, e});
        end
      end
    end
  end

  task automatic idle_reqs();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic drive(input logic id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end
  endtask

  task automatic wait_gnt(input logic id, output bit got);
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if ((id ? bus.gnt1 : bus.gnt0) === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("gnt_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      lat++;
      if (bus.resp_valid === 1'b1) break;
    end
    if (bus.resp_valid !== 1'b1) chk("resp_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin
    bit   got;
    int   lat;
    int   nresp;
    int   ng1;
    logic ids[4];
    logic [31:0] snap;

    tbl[0]  = '{1'b0, 3'd2, 32'd7,          32'hFFFF_FFFD, 32'd4,          1'b0, 1'b0};
    tbl[1]  = '{1'b1, 3'd7, 32'hFFFF_FFFF,  32'd1,         32'd1,          1'b0, 1'b0};
    tbl[2]  = '{1'b1, 3'd6, 32'h8000_0000,  32'd1,         32'h7FFF_FFFF,  1'b0, 1'b0};
    tbl[3]  = '{1'b0, 3'd5, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd0,          1'b0, 1'b1};
    tbl[4]  = '{1'b0, 3'd0, 32'h0000_00F0,  32'h0000_003C, 32'h0000_0030,  1'b0, 1'b0};
    tbl[5]  = '{1'b1, 3'd2, 32'hFFFF_FFFF,  32'd1,         32'd0,          1'b1, 1'b0};
    tbl[6]  = '{1'b0, 3'd7, 32'd1,          32'hFFFF_FFFF, 32'd0,          1'b1, 1'b0};
    tbl[7]  = '{1'b1, 3'd3, 32'h12,         32'h34,        32'd0,          1'b0, 1'b1};
    tbl[8]  = '{1'b0, 3'd4, 32'h55,         32'h66,        32'd0,          1'b0, 1'b1};
    tbl[9]  = '{1'b1, 3'd1, 32'd0,          32'd0,         32'd0,          1'b1, 1'b0};
    tbl[10] = '{1'b0, 3'd6, 32'd5,          32'd5,         32'd0,          1'b1, 1'b0};
    tbl[11] = '{1'b1, 3'd1, 32'h0000_00F0,  32'h0000_000C, 32'h0000_00FC,  1'b0, 1'b0};

    vec_cnt = 0;
    miss_cnt = 0;
    clk = 1'b0;
    rst_n = 1'b0;
    bus.resp_ready = 1'b1;
    bus.req0_op = 3'd0; bus.req0_a = 32'd0; bus.req0_b = 32'd0;
    bus.req1_op = 3'd0; bus.req1_a = 32'd0; bus.req1_b = 32'd0;
    idle_reqs();

    // Power-on reset.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    chk("rst_resp_fields", {29'd0, bus.resp_id, bus.resp_err, bus.resp_ex, bus.resp_z}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Table-driven single operations with resp_ready high.
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      drive(tbl[i].id, tbl[i].op, tbl[i].a, tbl[i].b);
      wait_gnt(tbl[i].id, got);
      @(posedge clk); #1;
      idle_reqs();
      wait_resp(lat);
      chk("latency", 64'(lat), 64'd2);
      chk("resp_z", {32'd0, bus.resp_z}, {32'd0, tbl[i].z});
      chk("resp_ex", {63'd0, bus.resp_ex}, {63'd0, tbl[i].ex});
      chk("resp_id", {63'd0, bus.resp_id}, {63'd0, tbl[i].id});
      chk("resp_err", {63'd0, bus.resp_err}, {63'd0, tbl[i].err});
    end
    drain();

    // Reset asserted while an op is in EXEC: it must be dropped.
    drive(1'b0, 3'd2, 32'd100, 32'd23);
    wait_gnt(1'b0, got);
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midrst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    chk("midrst_resp_fields", {29'd0, bus.resp_id, bus.resp_err, bus.resp_ex, bus.resp_z}, 64'd0);
    chk("midrst_no_gnt", {62'd0, bus.gnt1, bus.gnt0}, 64'd0);
    @(posedge clk); #1;
    idle_reqs();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("no_stale_resp", {63'd0, bus.resp_valid}, 64'd0);
    end

    // Tie: both requesters valid for four responses.
    @(posedge clk); #1;
    drive(1'b0, 3'd2, 32'd1, 32'd1);
    drive(1'b1, 3'd1, 32'd4, 32'd8);
    nresp = 0;
    ng1 = 0;
    for (int c = 0; c < 40 && nresp < 4; c++) begin
      @(negedge clk);
      if (bus.gnt1 === 1'b1) ng1++;
      if (bus.resp_valid === 1'b1 && bus.resp_ready === 1'b1) begin
        ids[nresp] = bus.resp_id;
        nresp++;
      end
    end
    chk("tie_resp_count", 64'(nresp), 64'd4);
    @(posedge clk); #1;
    idle_reqs();
`ifdef YALU_ARB_ROUND_ROBIN_EN
    chk("rr_id_seq", {60'd0, ids[0], ids[1], ids[2], ids[3]}, 64'b0101);
`else
    chk("fixed_id_seq", {60'd0, ids[0], ids[1], ids[2], ids[3]}, 64'b0000);
    chk("req1_starved", 64'(ng1), 64'd0);
`endif
    drain();

    // Backpressure: response held 5 cycles with req0 pending.
    bus.resp_ready = 1'b0;
    drive(1'b0, 3'd0, 32'h0000_00FF, 32'h0000_000F);
    wait_gnt(1'b0, got);
    wait_resp(lat);
    snap = bus.resp_z;
    chk("bp_first_z", {32'd0, snap}, 64'h0F);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      chk("bp_valid_held", {63'd0, bus.resp_valid}, 64'd1);
      chk("bp_z_stable", {32'd0, bus.resp_z}, {32'd0, snap});
      chk("bp_no_gnt", {62'd0, bus.gnt1, bus.gnt0}, 64'd0);
    end
    @(posedge clk); #1;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_gnt0", {63'd0, bus.gnt0}, 64'd1);
    @(posedge clk); #1;
    idle_reqs();
    wait_resp(lat);
    chk("bp_next_latency", 64'(lat), 64'd2);
    drain();

    chk("sb_drained", 64'(sbq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/yalu_arbiter.md
# yalu_arbiter

Sequencer and arbiter that shares a single `yAlu` instance between two requesters. It accepts one operation at a time through a valid/grant handshake and registers operands and opcode into the ALU. It captures `z`/`ex` one cycle later and returns the result on a shared response channel with valid/ready backpressure. It sits between the two issue sources of the datapath (for example, the integer pipe and the address-generation path) and the ALU.

## Interface
- `WIDTH`, 32: operand/result width; fixed to 32 in this revision to match `yAlu`.
- `clk`  in  1: sole clock, rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `req0_valid`, `req1_valid`  in  1 each: requester has an operation pending.
- `req0_op`, `req1_op`  in  3 each: ALU opcode (0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT).
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  32 each: signed operands.
- `gnt0`, `gnt1`  out  1 each: combinational; request accepted at this rising edge.
- `resp_valid`  out  1: result held on `resp_*`.
- `resp_ready`  in  1: consumer takes the result this edge.
- `resp_z`  out  32: ALU result.
- `resp_ex`  out  1: ALU `ex` flag, passed through.
- `resp_id`  out  1: index of the requester that issued the op.
- `resp_err`  out  1: opcode was illegal (3, 4 or 5).

## Operation
- States: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - If any `reqN_valid` is high, assert exactly one `gntN`.
  - At the edge, latch op, a, b and id into operand registers, then go to EXEC.
  - If no request is valid, stay in IDLE.
- EXEC:
  - The ALU is driven only from the operand registers.
  - At the edge, latch ALU `z`/`ex`, the id and the err flag into result registers, then go to RESP.
  - No grants are issued in EXEC.
- RESP:
  - `resp_valid`=1. `resp_*` is stable until the handshake completes.
  - On `resp_valid && resp_ready`:
    - With a request pending, grant it in the same cycle and go to EXEC (back-to-back issue).
    - With no request pending, go to IDLE.
  - Without `resp_ready`, stay in RESP with no grants.
- Grant is combinational in the cycle when `state==IDLE`, or when `state==RESP && resp_ready`.
- Arbitration when both requests are valid: see Configuration. A lone valid request is always granted.
- Illegal opcode (3, 4, 5):
  - The op still flows through EXEC.
  - `resp_err`=1, `resp_z`=0, `resp_ex`=0.
- Arithmetic is exactly that of `yAlu`:
  - ADD/SUB wrap modulo 2^32.
  - SLT is a signed compare: `resp_z` is 1 or 0, zero-extended.
- Requesters must hold `reqN_*` stable while `reqN_valid`=1 and `gntN`=0. The arbiter samples only on grant.

## Timing
- Reset: on any edge with `rst_n`=0 the block does the following, regardless of state, including mid-EXEC or mid-RESP (the in-flight op is dropped):
  - state=IDLE.
  - `resp_valid`=0, `resp_z`=0, `resp_ex`=0, `resp_id`=0, `resp_err`=0.
  - Round-robin pointer points to requester 0.
  - `gnt0`/`gnt1` are 0 while `rst_n`=0.
- Latency: grant at edge N gives `resp_valid`=1 after edge N+1 (visible during cycle N+1 to N+2). There is one EXEC cycle between grant and response.
- Throughput: one op per 2 cycles with `resp_ready` tied high (RESP→EXEC direct).
- `resp_valid` falls on the edge after handshake unless a new grant occurred in that same cycle. In that case it still falls for the EXEC cycle.
- `gntN` never asserts while `reqN_valid`=0. At most one of `gnt0`/`gnt1` is high in any cycle.

## Configuration
- `YALU_ARB_ROUND_ROBIN_EN`:
  - Defined: round-robin arbitration. The pointer flips to the other requester after every grant. On a tie, the requester the pointer indicates wins.
  - Undefined: fixed priority, requester 0 always wins ties, and the pointer register is not built.

## Test plan
- Reset: drive `rst_n`=0 for 2 cycles in EXEC with an op in flight → IDLE, `resp_valid`=0, all `resp_*`=0, no stale response after release.
- Single ADD: req0 op=2, a=7, b=−3, `resp_ready`=1 → `gnt0` at cycle 0, `resp_valid` at cycle 1, `resp_z`=4, `resp_id`=0, `resp_err`=0.
- SLT/SUB signed: req1 op=7 a=−1 b=1 → `resp_z`=1; then op=6 a=0x80000000 b=1 → `resp_z`=0x7FFFFFFF.
- Tie, both valid continuously, 4 ops:
  - With `YALU_ARB_ROUND_ROBIN_EN` → `resp_id` sequence 0,1,0,1.
  - Without it → 0,0,0,0, with req1 starved.
- Backpressure: hold `resp_ready`=0 for 5 cycles in RESP with req0 valid → `resp_*` stable, no grants; raise `resp_ready` → same-cycle `gnt0`, next response 2 cycles later.
- Illegal op=5, a=b=0xFFFFFFFF → `resp_err`=1, `resp_z`=0, `resp_ex`=0; the following legal op (AND a=0xF0 b=0x3C → 0x30) is unaffected.
